// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: select encodings,
// default preset divisors and the clamp that keeps a zero divisor out of the datapath.
package clk_div_pkg;

    typedef enum logic [1:0] {
        SEL_P0   = 2'b00,
        SEL_P1   = 2'b01,
        SEL_P2   = 2'b10,
        SEL_PROG = 2'b11
    } sel_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_PRESET0 = 32;
    localparam int DEF_PRESET1 = 8;
    localparam int DEF_PRESET2 = 4;
    localparam int DEF_PCNT_W  = 8;

    // A divisor of 0 has no meaningful period, so it is promoted to 1.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/clk_div_period_ctr.sv
// Period counter: boundary detect plus registered clk_out, tick and period count.
// All outputs update one clk_in edge after the inputs; en=0 freezes everything except tick.
module clk_div_period_ctr #(
    parameter int CNT_W  = 16,
    parameter int PCNT_W = 8
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  div,
    input  logic [CNT_W-1:0]  next_div,
    output logic              boundary,
    output logic              clk_out,
    output logic              tick,
    output logic [PCNT_W-1:0] period_cnt
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W:0]   half;
    logic             reload;
    logic             wrap;

    always_comb begin
        wrap     = (cnt == div - CNT_W'(1));
        boundary = en && (reload || wrap);
        cnt_nxt  = cnt;
        div_nxt  = div;
        if (boundary) begin
            cnt_nxt = '0;
            div_nxt = next_div;
        end else if (en) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        // High phase is ceil(D/2) of the divisor that will be in force after this edge.
        half = ({1'b0, div_nxt} + (CNT_W + 1)'(1)) >> 1;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt        <= '0;
            reload     <= 1'b1;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            period_cnt <= '0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= en && wrap;
            if (boundary) begin
                reload <= 1'b0;
            end
            if (en) begin
                clk_out <= ({1'b0, cnt_nxt} < half);
            end
            if (en && wrap) begin
                period_cnt <= period_cnt + PCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable divider top: divisor select, programmed-divisor register and write handshake.
// Divisor changes land only at period boundaries; cfg_ready stays low while a write is pending.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRESET0 = DEF_PRESET0,
    parameter int PRESET1 = DEF_PRESET1,
    parameter int PRESET2 = DEF_PRESET2,
    parameter int PCNT_W  = DEF_PCNT_W
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        sel,
    input  logic              cfg_valid,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic              clk_out,
    output logic              tick,
    output logic [PCNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0]  active_div
);

    localparam logic [CNT_W-1:0] P0 = CNT_W'(clamp_div(32'(PRESET0)));
    localparam logic [CNT_W-1:0] P1 = CNT_W'(clamp_div(32'(PRESET1)));
    localparam logic [CNT_W-1:0] P2 = CNT_W'(clamp_div(32'(PRESET2)));

    logic [CNT_W-1:0] prog_div;
    logic [CNT_W-1:0] next_div;
    logic             pending;
    logic             accept;
    logic             boundary;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid && ~pending;

    always_comb begin
        next_div = P0;
        case (sel_t'(sel))
            SEL_P0:   next_div = P0;
            SEL_P1:   next_div = P1;
            SEL_P2:   next_div = P2;
            SEL_PROG: next_div = prog_div;
            default:  next_div = P0;
        endcase
    end

    // An accept coinciding with a boundary keeps pending set: the boundary
    // consumes the old prog_div and the new value waits for the next one.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            active_div <= P0;
            prog_div   <= P0;
            pending    <= 1'b0;
        end else begin
            if (boundary) begin
                active_div <= next_div;
            end
            if (accept) begin
                prog_div <= CNT_W'(clamp_div(32'(cfg_div)));
                pending  <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    clk_div_period_ctr #(
        .CNT_W  (CNT_W),
        .PCNT_W (PCNT_W)
    ) u_period_ctr (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .div        (active_div),
        .next_div   (next_div),
        .boundary   (boundary),
        .clk_out    (clk_out),
        .tick       (tick),
        .period_cnt (period_cnt)
    );

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with PRESET0=4, PRESET1=8, PRESET2=2.
module tb_clk_div_prog;

    localparam int CNT_W  = 16;
    localparam int PCNT_W = 8;

    logic              clk_in;
    logic              rst;
    logic              en;
    logic [1:0]        sel;
    logic              cfg_valid;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic              clk_out;
    logic              tick;
    logic [PCNT_W-1:0] period_cnt;
    logic [CNT_W-1:0]  active_div;

    int checks;
    int failures;

    clk_div_prog #(
        .CNT_W   (CNT_W),
        .PRESET0 (4),
        .PRESET1 (8),
        .PRESET2 (2),
        .PCNT_W  (PCNT_W)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .sel        (sel),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .clk_out    (clk_out),
        .tick       (tick),
        .period_cnt (period_cnt),
        .active_div (active_div)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; sel = 2'b00; cfg_valid = 1'b0; cfg_div = '0;
        step();
        step();
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (period_cnt !== 8'd0) begin failures++; $display("FAIL reset_pcnt got=%0d exp=0", period_cnt); end
        checks++; if (active_div !== 16'd4) begin failures++; $display("FAIL reset_div got=%0d exp=4", active_div); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    endtask

    task automatic test_preset0();
        logic exp_clk;
        logic exp_tick;
        rst = 1'b0; en = 1'b1; sel = 2'b00;
        for (int k = 0; k <= 12; k++) begin
            step();
            exp_clk  = ((k % 4) < 2);
            exp_tick = (k > 0) && ((k % 4) == 0);
            checks++; if (clk_out !== exp_clk) begin failures++; $display("FAIL p0_clk_out edge=%0d got=%b exp=%b", k, clk_out, exp_clk); end
            checks++; if (tick !== exp_tick) begin failures++; $display("FAIL p0_tick edge=%0d got=%b exp=%b", k, tick, exp_tick); end
        end
        checks++; if (period_cnt !== 8'd3) begin failures++; $display("FAIL p0_pcnt got=%0d exp=3", period_cnt); end
    endtask

    task automatic test_sel_change();
        logic       exp_clk  [8];
        logic       exp_tick [8];
        logic [15:0] exp_div [8];
        exp_clk  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_tick = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_div  = '{16'd4, 16'd4, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2};
        step();
        sel = 2'b10;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (clk_out !== exp_clk[k]) begin failures++; $display("FAIL sel_clk_out i=%0d got=%b exp=%b", k, clk_out, exp_clk[k]); end
            checks++; if (tick !== exp_tick[k]) begin failures++; $display("FAIL sel_tick i=%0d got=%b exp=%b", k, tick, exp_tick[k]); end
            checks++; if (active_div !== exp_div[k]) begin failures++; $display("FAIL sel_div i=%0d got=%0d exp=%0d", k, active_div, exp_div[k]); end
        end
        checks++; if (period_cnt !== 8'd6) begin failures++; $display("FAIL sel_pcnt got=%0d exp=6", period_cnt); end
    endtask

    task automatic test_prog_write();
        logic exp_clk;
        logic exp_tick;
        step();
        sel = 2'b11; cfg_valid = 1'b1; cfg_div = 16'd5;
        step();
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL prog_ready_busy got=%b exp=0", cfg_ready); end
        checks++; if (active_div !== 16'd2) begin failures++; $display("FAIL prog_div_hold got=%0d exp=2", active_div); end
        cfg_div = 16'd7;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL prog_ready_free got=%b exp=1", cfg_ready); end
        checks++; if (active_div !== 16'd5) begin failures++; $display("FAIL prog_div_new got=%0d exp=5", active_div); end
        checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL prog_clk_first got=%b exp=1", clk_out); end
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_clk  = ((k % 5) < 3);
            exp_tick = ((k % 5) == 0);
            checks++; if (clk_out !== exp_clk) begin failures++; $display("FAIL prog_clk_out k=%0d got=%b exp=%b", k, clk_out, exp_clk); end
            checks++; if (tick !== exp_tick) begin failures++; $display("FAIL prog_tick k=%0d got=%b exp=%b", k, tick, exp_tick); end
        end
        checks++; if (active_div !== 16'd5) begin failures++; $display("FAIL prog_div_kept got=%0d exp=5", active_div); end
        checks++; if (period_cnt !== 8'd10) begin failures++; $display("FAIL prog_pcnt got=%0d exp=10", period_cnt); end
    endtask

    task automatic test_div_zero();
        cfg_valid = 1'b1; cfg_div = 16'd0;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL zero_ready got=%b exp=0", cfg_ready); end
        for (int k = 0; k < 4; k++) step();
        checks++; if (active_div !== 16'd1) begin failures++; $display("FAIL zero_div got=%0d exp=1", active_div); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL zero_ready_free got=%b exp=1", cfg_ready); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            checks++; if (tick !== 1'b1) begin failures++; $display("FAIL zero_tick k=%0d got=%b exp=1", k, tick); end
            checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL zero_clk_out k=%0d got=%b exp=1", k, clk_out); end
        end
        checks++; if (period_cnt !== 8'd15) begin failures++; $display("FAIL zero_pcnt got=%0d exp=15", period_cnt); end
    endtask

    task automatic test_enable_freeze();
        sel = 2'b00;
        step();
        checks++; if (active_div !== 16'd4) begin failures++; $display("FAIL frz_div got=%0d exp=4", active_div); end
        step();
        step();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL frz_clk_out k=%0d got=%b exp=0", k, clk_out); end
            checks++; if (tick !== 1'b0) begin failures++; $display("FAIL frz_tick k=%0d got=%b exp=0", k, tick); end
            checks++; if (period_cnt !== 8'd16) begin failures++; $display("FAIL frz_pcnt k=%0d got=%0d exp=16", k, period_cnt); end
        end
        en = 1'b1;
        step();
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL frz_resume_tick got=%b exp=0", tick); end
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL frz_resume_clk got=%b exp=0", clk_out); end
        step();
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL frz_done_tick got=%b exp=1", tick); end
        checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL frz_done_clk got=%b exp=1", clk_out); end
        checks++; if (period_cnt !== 8'd17) begin failures++; $display("FAIL frz_done_pcnt got=%0d exp=17", period_cnt); end
    endtask

    task automatic test_reset_mid();
        sel = 2'b01;
        for (int k = 0; k < 6; k++) step();
        checks++; if (active_div !== 16'd8) begin failures++; $display("FAIL rmid_div8 got=%0d exp=8", active_div); end
        checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL rmid_clk_pre got=%b exp=1", clk_out); end
        rst = 1'b1; sel = 2'b11;
        step();
        checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL rmid_clk got=%b exp=0", clk_out); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL rmid_tick got=%b exp=0", tick); end
        checks++; if (period_cnt !== 8'd0) begin failures++; $display("FAIL rmid_pcnt got=%0d exp=0", period_cnt); end
        checks++; if (active_div !== 16'd4) begin failures++; $display("FAIL rmid_div got=%0d exp=4", active_div); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", cfg_ready); end
        rst = 1'b0;
        step();
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL rmid_reload_tick got=%b exp=0", tick); end
        checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL rmid_reload_clk got=%b exp=1", clk_out); end
        checks++; if (active_div !== 16'd4) begin failures++; $display("FAIL rmid_prog_div got=%0d exp=4", active_div); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_preset0();
        test_sel_change();
        test_prog_write();
        test_div_zero();
        test_enable_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
